retry_num_tracker: RTL and testbench
====================================

Name: retry_num_tracker

Overview:
Parametrised NUM_RETRY / NUM_PHY_REINIT tracker for the CXL link-layer retry controller.
- Counts retry attempts and compares the peer's RETRY.Req NUM_RETRY against the local count.
- Escalates to a physical-layer reinit request when MAX_NUM_RETRY is exhausted.
- Declares link failure once MAX_NUM_PHY_REINIT reinits have been spent.
- Sits between the retry-controller FSM and the LRSM/PHY-reinit logic.

Parameters:
CNT_W, 5, width of NUM_RETRY counter and request field.
MAX_NUM_RETRY, 31, retry attempts allowed before PHY reinit; must be 1..2^CNT_W-1 (elaboration error otherwise).
PHY_W, 3, width of NUM_PHY_REINIT counter.
MAX_NUM_PHY_REINIT, 3, PHY reinits allowed before link failure; must be 1..2^PHY_W-1.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_retryreq_num  in  CNT_W  NUM_RETRY field of received RETRY.Req
i_retryreq_valid  in  1  i_retryreq_num valid this cycle
i_retryable_flit_detected  in  1  clear NUM_RETRY (successful retry)
i_empty_bit_detected  in  1  clear NUM_RETRY
i_num_retry_clr  in  1  clear NUM_RETRY (controller request)
i_num_retry_inc  in  1  one more retry attempt
i_phy_reinit_done  in  1  PHY reinit completed
i_num_phy_reinit_clr  in  1  clear NUM_PHY_REINIT, exit FAILED
o_num_retry  out  CNT_W  current NUM_RETRY
o_num_retry_matches  out  1  request matches local count
o_phy_reinit_req  out  1  level request to PHY reinit logic
o_num_phy_reinit  out  PHY_W  current NUM_PHY_REINIT
o_link_failed  out  1  sticky link-failure flag
o_state  out  2  FSM state: 0 NORMAL, 1 RETRY, 2 PHY_REINIT, 3 FAILED

Behaviour:
- One clock i_clk; reset i_rst_n asynchronous, active-low.
- Reset values: state NORMAL; all outputs 0.

State NORMAL and RETRY:
- Clear = i_retryable_flit_detected | i_empty_bit_detected | i_num_retry_clr. Clear has priority over i_num_retry_inc: count<=0, state<=NORMAL.
- Inc with count < MAX_NUM_RETRY: count+1; state<=RETRY.
- Inc with count == MAX_NUM_RETRY (exhausted):
  - count<=0.
  - If o_num_phy_reinit < MAX_NUM_PHY_REINIT: o_num_phy_reinit+1, state<=PHY_REINIT.
  - Else: state<=FAILED, o_num_phy_reinit held.
- Counter never wraps.

State PHY_REINIT:
- o_phy_reinit_req=1 (Moore, asserted the cycle after entry).
- inc and clears ignored; count held 0.
- i_phy_reinit_done -> NORMAL next cycle; req drops the same cycle.

State FAILED:
- o_link_failed=1; inc ignored; count held 0.
- Exits only on i_num_phy_reinit_clr -> NORMAL.

i_num_phy_reinit_clr (any state):
- o_num_phy_reinit<=0.
- If it coincides with an exhausting inc: clear wins, counter ends at 0, and the transition goes to PHY_REINIT, never FAILED.

Match:
- o_num_retry_matches = i_retryreq_valid & (o_num_retry != 0) & (i_retryreq_num == o_num_retry - 1), with the subtraction taken mod 2^CNT_W.
- Forced 0 when count is 0 (no wrap-around false match) and in PHY_REINIT/FAILED.
- Combinational: 0-cycle latency from inputs and current count.

Optional Feature:
Macro RETRY_NUM_MATCH_REG_EN.
- Defined: o_num_retry_matches is registered and appears one cycle after i_retryreq_valid, computed from the pre-update count of that cycle. Resets to 0.
- Undefined: combinational as above.

Test Plan:
1. Reset with CNT_W=5, MAX_NUM_RETRY=4 -> all outputs 0, o_state=0.
2. Three inc pulses, then retryreq_num=2 valid -> o_num_retry=3, o_state=1, matches=1. Same with retryreq_num=3 -> matches=0.
3. Count 0 and retryreq_num=31 valid -> matches=0 (no wrap match).
4. Inc and i_num_retry_clr in the same cycle at count 2 -> count 0, state NORMAL.
5. Five incs with MAX_NUM_RETRY=4 -> count 0, o_num_phy_reinit=1, o_phy_reinit_req=1. While pending, further inc ignored. i_phy_reinit_done -> state 0, req 0.
6. MAX_NUM_PHY_REINIT=1: exhaust twice (done between) -> o_link_failed=1, state 3, num_phy_reinit=1. i_num_phy_reinit_clr -> state 0, flags 0. With RETRY_NUM_MATCH_REG_EN, repeat case 2 -> matches asserted one cycle later.

Source files
------------

// File: rtl/retry_num_tracker_if.sv
// Signal bundle between the retry-controller FSM and the NUM_RETRY / NUM_PHY_REINIT tracker.
// master: retry controller side; slave: tracker side.
interface retry_num_tracker_if #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned PHY_W = 3
);
    logic [CNT_W-1:0] i_retryreq_num;
    logic             i_retryreq_valid;
    logic             i_retryable_flit_detected;
    logic             i_empty_bit_detected;
    logic             i_num_retry_clr;
    logic             i_num_retry_inc;
    logic             i_phy_reinit_done;
    logic             i_num_phy_reinit_clr;
    logic [CNT_W-1:0] o_num_retry;
    logic             o_num_retry_matches;
    logic             o_phy_reinit_req;
    logic [PHY_W-1:0] o_num_phy_reinit;
    logic             o_link_failed;
    logic [1:0]       o_state;

    modport master (
        output i_retryreq_num, i_retryreq_valid, i_retryable_flit_detected,
               i_empty_bit_detected, i_num_retry_clr, i_num_retry_inc,
               i_phy_reinit_done, i_num_phy_reinit_clr,
        input  o_num_retry, o_num_retry_matches, o_phy_reinit_req,
               o_num_phy_reinit, o_link_failed, o_state
    );

    modport slave (
        input  i_retryreq_num, i_retryreq_valid, i_retryable_flit_detected,
               i_empty_bit_detected, i_num_retry_clr, i_num_retry_inc,
               i_phy_reinit_done, i_num_phy_reinit_clr,
        output o_num_retry, o_num_retry_matches, o_phy_reinit_req,
               o_num_phy_reinit, o_link_failed, o_state
    );
endinterface

// File: rtl/retry_num_tracker.sv
// NUM_RETRY / NUM_PHY_REINIT tracker: counts retries, escalates to PHY reinit, then link failure.
// Optional macro RETRY_NUM_MATCH_REG_EN registers o_num_retry_matches (one cycle later).
module retry_num_tracker #(
    parameter int unsigned CNT_W              = 5,
    parameter int unsigned MAX_NUM_RETRY      = 31,
    parameter int unsigned PHY_W              = 3,
    parameter int unsigned MAX_NUM_PHY_REINIT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    retry_num_tracker_if.slave   bus
);

    if (MAX_NUM_RETRY < 1 || MAX_NUM_RETRY > ((32'd1 << CNT_W) - 32'd1)) begin : g_bad_max_retry
        $error("MAX_NUM_RETRY must be in 1..2^CNT_W-1");
    end
    if (MAX_NUM_PHY_REINIT < 1 || MAX_NUM_PHY_REINIT > ((32'd1 << PHY_W) - 32'd1)) begin : g_bad_max_phy
        $error("MAX_NUM_PHY_REINIT must be in 1..2^PHY_W-1");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUM_RETRY);
    localparam logic [PHY_W-1:0] MAX_PHY = PHY_W'(MAX_NUM_PHY_REINIT);

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_RETRY      = 2'd1,
        ST_PHY_REINIT = 2'd2,
        ST_FAILED     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PHY_W-1:0] phy_q, phy_d;
    logic             retry_clr;
    logic             match_c;
    logic             phy_reinit_req_c;
    logic             link_failed_c;

    // State and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            phy_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phy_q   <= phy_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phy_d     = phy_q;
        retry_clr = bus.i_retryable_flit_detected | bus.i_empty_bit_detected | bus.i_num_retry_clr;
        case (state_q)
            ST_NORMAL, ST_RETRY: begin
                if (retry_clr) begin
                    cnt_d   = '0;
                    state_d = ST_NORMAL;
                end else if (bus.i_num_retry_inc) begin
                    if (cnt_q < MAX_CNT) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_RETRY;
                    end else begin
                        cnt_d = '0;
                        // A coincident reinit-count clear frees a reinit slot, so never FAILED
                        if (bus.i_num_phy_reinit_clr) begin
                            state_d = ST_PHY_REINIT;
                        end else if (phy_q < MAX_PHY) begin
                            phy_d   = phy_q + PHY_W'(1);
                            state_d = ST_PHY_REINIT;
                        end else begin
                            state_d = ST_FAILED;
                        end
                    end
                end
            end
            ST_PHY_REINIT: begin
                cnt_d = '0;
                if (bus.i_phy_reinit_done) state_d = ST_NORMAL;
            end
            ST_FAILED: begin
                cnt_d = '0;
                if (bus.i_num_phy_reinit_clr) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
        if (bus.i_num_phy_reinit_clr) phy_d = '0;
    end

    // Moore flags and peer NUM_RETRY comparison
    always_comb begin
        phy_reinit_req_c = (state_q == ST_PHY_REINIT);
        link_failed_c    = (state_q == ST_FAILED);
        match_c          = bus.i_retryreq_valid
                         & (cnt_q != '0)
                         & ((state_q == ST_NORMAL) | (state_q == ST_RETRY))
                         & (bus.i_retryreq_num == (cnt_q - CNT_W'(1)));
    end

`ifdef RETRY_NUM_MATCH_REG_EN
    logic match_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) match_q <= 1'b0;
        else          match_q <= match_c;
    end
    assign bus.o_num_retry_matches = match_q;
`else
    assign bus.o_num_retry_matches = match_c;
`endif

    assign bus.o_num_retry      = cnt_q;
    assign bus.o_num_phy_reinit = phy_q;
    assign bus.o_phy_reinit_req = phy_reinit_req_c;
    assign bus.o_link_failed    = link_failed_c;
    assign bus.o_state          = state_q;

endmodule

// File: tb/tb_retry_num_tracker.sv
// Directed bench for retry_num_tracker with MAX_NUM_RETRY=4, MAX_NUM_PHY_REINIT=1.
module tb_retry_num_tracker;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned PHY_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retry_num_tracker_if #(.CNT_W(CNT_W), .PHY_W(PHY_W)) bus ();

    retry_num_tracker #(
        .CNT_W(CNT_W), .MAX_NUM_RETRY(4), .PHY_W(PHY_W), .MAX_NUM_PHY_REINIT(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic             inc, clr, rff, eb, done, pclr, valid;
        logic [CNT_W-1:0] num;
        logic [CNT_W-1:0] e_cnt;
        logic [1:0]       e_st;
        logic [PHY_W-1:0] e_phy;
        logic             e_match;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input int inc, input int clr, input int rff, input int eb,
                                input int done, input int pclr, input int valid, input int num,
                                input int e_cnt, input int e_st, input int e_phy, input int e_match);
        vec_t v;
        v.inc = 1'(inc); v.clr = 1'(clr); v.rff = 1'(rff); v.eb = 1'(eb);
        v.done = 1'(done); v.pclr = 1'(pclr); v.valid = 1'(valid);
        v.num = CNT_W'(num); v.e_cnt = CNT_W'(e_cnt); v.e_st = 2'(e_st);
        v.e_phy = PHY_W'(e_phy); v.e_match = 1'(e_match);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_retryreq_num = '0; bus.i_retryreq_valid = 1'b0;
        bus.i_retryable_flit_detected = 1'b0; bus.i_empty_bit_detected = 1'b0;
        bus.i_num_retry_clr = 1'b0; bus.i_num_retry_inc = 1'b0;
        bus.i_phy_reinit_done = 1'b0; bus.i_num_phy_reinit_clr = 1'b0;
    endtask

    task automatic check_regs(input string tag, input int cnt, input int st, input int phy);
        chk({tag, "_cnt"},    int'(bus.o_num_retry), cnt);
        chk({tag, "_state"},  int'(bus.o_state), st);
        chk({tag, "_phy"},    int'(bus.o_num_phy_reinit), phy);
        chk({tag, "_req"},    int'(bus.o_phy_reinit_req), (st == 2) ? 1 : 0);
        chk({tag, "_failed"}, int'(bus.o_link_failed), (st == 3) ? 1 : 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.i_num_retry_inc = v.inc; bus.i_num_retry_clr = v.clr;
        bus.i_retryable_flit_detected = v.rff; bus.i_empty_bit_detected = v.eb;
        bus.i_phy_reinit_done = v.done; bus.i_num_phy_reinit_clr = v.pclr;
        bus.i_retryreq_valid = v.valid; bus.i_retryreq_num = v.num;
        #2;
`ifndef RETRY_NUM_MATCH_REG_EN
        chk({tag, "_match"}, int'(bus.o_num_retry_matches), int'(v.e_match));
`endif
        @(posedge clk);
        #1;
        check_regs(tag, int'(v.e_cnt), int'(v.e_st), int'(v.e_phy));
`ifdef RETRY_NUM_MATCH_REG_EN
        chk({tag, "_match"}, int'(bus.o_num_retry_matches), int'(v.e_match));
`endif
    endtask

    initial begin
        int n_cyc;
        //              inc clr rff eb dn pclr vld num  cnt st phy m
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0)); // 1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2,  3, 1, 0, 1)); // peer num 2 vs count 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  3,  3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 31,  0, 0, 0, 0)); // no wrap match
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0)); // 10: clear beats inc
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 2, 1, 0)); // 15: exhaust -> reinit
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0,  0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 31,  0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,  0, 0, 1, 0)); // done
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0,  0, 0, 1, 0)); // 20
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  4, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 3, 1, 0)); // 25: second exhaust -> FAILED
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,  0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0)); // reinit clear exits FAILED
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 0, 0)); // 30
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 1, 0)); // 35
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  4, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  3,  0, 2, 0, 1)); // exhaust + reinit clear
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0,  0, 0, 0, 0)); // 40
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0,  0, 0, 0, 0)); // empty bit beats inc

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 0, 0, 0);
        chk("reset_match", int'(bus.o_num_retry_matches), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i + 1);

        // Asynchronous reset mid-cycle from a non-zero count
        @(negedge clk);
        drive_idle();
        bus.i_num_retry_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_async_cnt", int'(bus.o_num_retry), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", int'(bus.o_num_retry), 0);
        chk("async_rst_state", int'(bus.o_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Held inc: reinit request after exactly five edges, then inc is ignored
        n_cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_phy_reinit_req) begin
                n_cyc = k;
                break;
            end
        end
        chk("req_latency", n_cyc, 5);
        repeat (3) @(posedge clk);
        #1;
        check_regs("req_hold", 0, 2, 1);
        @(negedge clk);
        bus.i_num_retry_inc = 1'b0;
        bus.i_phy_reinit_done = 1'b1;
        @(posedge clk);
        #1;
        check_regs("done_exit", 0, 0, 1);
        @(negedge clk);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
